// File: rtl/cpu_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cpu_pkg : shared CPU types for the memory arbiter and its neighbours.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package cpu_pkg;

  localparam int ADDR_W = 14;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_WAIT = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_t;

  typedef enum logic {
    REQ_IF = 1'b0,
    REQ_D  = 1'b1
  } req_id_t;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_arbiter : single-port memory shared by instruction fetch and MEM     |
// | stage; data has priority, a grant streak limit keeps fetch moving.       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module mem_arbiter
  import cpu_pkg::*;
#(
  parameter int ADDR_W     = cpu_pkg::ADDR_W,
  parameter int DATA_W     = cpu_pkg::DATA_W,
  parameter int RD_LAT     = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_ready,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [DATA_W/8-1:0] d_wstrb,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_ready,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                mem_en,
  output logic [DATA_W/8-1:0] mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int LAT_W  = (RD_LAT < 1) ? 1 : $clog2(RD_LAT + 1);
  localparam int STRK_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [LAT_W-1:0]  LAT_LAST = LAT_W'(RD_LAT);
  localparam logic [STRK_W-1:0] STRK_MAX = STRK_W'(STARVE_MAX);

  arb_state_t          state_q, state_d;
  req_id_t             owner_q, owner_d;
  logic [LAT_W-1:0]    lat_q, lat_d;
  logic [STRK_W-1:0]   streak_q, streak_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
  logic                if_rvalid_q, if_rvalid_d;
  logic                d_rvalid_q, d_rvalid_d;

  logic                accept_ok;
  logic                grant_d;
  logic                grant_if;
  logic [STRK_W-1:0]   streak_inc;

  // Fetch overrides data only once data has won STARVE_MAX times in a row.
  always_comb begin
    accept_ok  = (state_q == ARB_IDLE) && !rst;
    grant_d    = accept_ok && d_req && !(if_req && (streak_q == STRK_MAX));
    grant_if   = accept_ok && if_req && !grant_d;
    streak_inc = (streak_q == STRK_MAX) ? streak_q : streak_q + STRK_W'(1);
  end

  assign if_ready  = grant_if;
  assign d_ready   = grant_d;
  assign mem_en    = grant_if | grant_d;
  assign mem_we    = (grant_d && d_we) ? d_wstrb : '0;
  assign mem_addr  = grant_d ? d_addr : (grant_if ? if_addr : '0);
  assign mem_wdata = (grant_d && d_we) ? d_wdata : '0;

  assign if_rvalid = if_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign d_rvalid  = d_rvalid_q;
  assign d_rdata   = d_rdata_q;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    lat_d       = lat_q;
    streak_d    = streak_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if_rvalid_d = 1'b0;
    d_rvalid_d  = 1'b0;

    case (state_q)
      ARB_IDLE: begin
        if (grant_d) begin
          owner_d  = REQ_D;
          streak_d = if_req ? streak_inc : '0;
          if (d_we) begin
            // Writes complete at the accept edge; the ack carries zero data.
            state_d    = ARB_RESP;
            d_rvalid_d = 1'b1;
            d_rdata_d  = '0;
          end else begin
            state_d = ARB_WAIT;
            lat_d   = LAT_W'(1);
          end
        end else if (grant_if) begin
          owner_d  = REQ_IF;
          streak_d = '0;
          state_d  = ARB_WAIT;
          lat_d    = LAT_W'(1);
        end
      end
      ARB_WAIT: begin
        if (lat_q == LAT_LAST) begin
          state_d = ARB_RESP;
          if (owner_q == REQ_D) begin
            d_rdata_d  = mem_rdata;
            d_rvalid_d = 1'b1;
          end else begin
            if_rdata_d  = mem_rdata;
            if_rvalid_d = 1'b1;
          end
        end else begin
          lat_d = lat_q + LAT_W'(1);
        end
      end
      ARB_RESP: state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ARB_IDLE;
      owner_q     <= REQ_IF;
      lat_q       <= '0;
      streak_q    <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      lat_q       <= lat_d;
      streak_q    <= streak_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      if_rvalid_q <= if_rvalid_d;
      d_rvalid_q  <= d_rvalid_d;
    end
  end

endmodule : mem_arbiter
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mem_arbiter : directed and random stimulus against a transaction-     |
// | level model of the arbiter, plus a memory with fixed read latency.       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_mem_arbiter;

  localparam int A_W   = 14;
  localparam int D_W   = 32;
  localparam int LAT   = 2;
  localparam int SMAX  = 4;
  localparam int SB    = D_W / 8;
  localparam int DEPTH = 1 << A_W;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           if_req = 1'b0;
  logic [A_W-1:0] if_addr = '0;
  logic           if_ready, if_rvalid;
  logic [D_W-1:0] if_rdata;
  logic           d_req = 1'b0;
  logic           d_we = 1'b0;
  logic [SB-1:0]  d_wstrb = '0;
  logic [A_W-1:0] d_addr = '0;
  logic [D_W-1:0] d_wdata = '0;
  logic           d_ready, d_rvalid;
  logic [D_W-1:0] d_rdata;
  logic           mem_en;
  logic [SB-1:0]  mem_we;
  logic [A_W-1:0] mem_addr;
  logic [D_W-1:0] mem_wdata;
  logic [D_W-1:0] mem_rdata;

  always #5 clk = ~clk;

  mem_arbiter #(
    .ADDR_W(A_W), .DATA_W(D_W), .RD_LAT(LAT), .STARVE_MAX(SMAX)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_wstrb(d_wstrb), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_ready(d_ready), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  function automatic logic [D_W-1:0] init_word(input logic [A_W-1:0] a);
    if (a == 14'h010) return 32'h00500093;
    if (a == 14'h020) return '0;
    return ({18'h0, a} * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  function automatic logic [D_W-1:0] merge(input logic [D_W-1:0] old,
                                          input logic [D_W-1:0] wd,
                                          input logic [SB-1:0] strb);
    logic [D_W-1:0] r;
    r = old;
    for (int b = 0; b < SB; b++)
      if (strb[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  // Memory seen by the DUT: read data appears LAT cycles after mem_en, noise otherwise.
  logic [D_W-1:0] env_mem [DEPTH];
  bit             env_wr  [DEPTH];
  logic [D_W-1:0] pipe    [LAT];
  assign mem_rdata = pipe[LAT-1];

  function automatic logic [D_W-1:0] env_read(input logic [A_W-1:0] a);
    return env_wr[a] ? env_mem[a] : init_word(a);
  endfunction

  always @(posedge clk) begin
    if (mem_en && mem_we != '0) begin
      env_mem[mem_addr] <= merge(env_read(mem_addr), mem_wdata, mem_we);
      env_wr[mem_addr]  <= 1'b1;
    end
    pipe[0] <= (mem_en && mem_we == '0) ? env_read(mem_addr) : $urandom;
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end

  // Reference model: one transaction at a time, described by its response cycle.
  logic [D_W-1:0] ref_mem [DEPTH];
  bit             ref_wr  [DEPTH];
  int             cyc = 0;
  bit             busy = 0;
  bit             own_d = 0;
  int             resp_cyc = 0;
  int             free_cyc = 0;
  int             streak = 0;
  logic [D_W-1:0] resp_data = '0;
  logic [D_W-1:0] exp_if_rdata = '0;
  logic [D_W-1:0] exp_d_rdata = '0;

  int checks = 0;
  int errors = 0;

  bit             s_if_ready, s_d_ready, s_if_rv, s_d_rv, s_mem_en;
  logic [D_W-1:0] s_if_rdata, s_d_rdata;

  function automatic logic [D_W-1:0] ref_read(input logic [A_W-1:0] a);
    return ref_wr[a] ? ref_mem[a] : init_word(a);
  endfunction

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string nm);
    checks++;
    errors++;
    $display("FAIL timeout_%s: no response within bound (cycle %0d)", nm, cyc);
  endtask

  task automatic model_reset();
    busy = 0;
    streak = 0;
    exp_if_rdata = '0;
    exp_d_rdata = '0;
  endtask

  // Inputs are set at a falling edge; settle, compare, advance the model, next falling edge.
  task automatic step();
    bit idle, wd, wi;
    logic [SB-1:0] ewe;
    #1;
    s_if_ready = if_ready; s_d_ready = d_ready;
    s_if_rv = if_rvalid;   s_d_rv = d_rvalid;
    s_mem_en = mem_en;
    s_if_rdata = if_rdata; s_d_rdata = d_rdata;
    if (rst) begin
      chk1("rst_if_ready", if_ready, 1'b0);
      chk1("rst_d_ready", d_ready, 1'b0);
      chk1("rst_if_rvalid", if_rvalid, 1'b0);
      chk1("rst_d_rvalid", d_rvalid, 1'b0);
      chk1("rst_mem_en", mem_en, 1'b0);
      chk32("rst_mem_we", 32'(mem_we), 32'h0);
      chk32("rst_if_rdata", if_rdata, 32'h0);
      chk32("rst_d_rdata", d_rdata, 32'h0);
      model_reset();
    end else begin
      if (busy && cyc == resp_cyc) begin
        if (own_d) exp_d_rdata = resp_data;
        else       exp_if_rdata = resp_data;
      end
      chk1("if_rvalid", if_rvalid, busy && cyc == resp_cyc && !own_d);
      chk1("d_rvalid", d_rvalid, busy && cyc == resp_cyc && own_d);
      chk32("if_rdata", if_rdata, exp_if_rdata);
      chk32("d_rdata", d_rdata, exp_d_rdata);
      if (busy && cyc == free_cyc) busy = 0;
      idle = !busy;
      wd = idle && d_req && !(if_req && streak == SMAX);
      wi = idle && if_req && !wd;
      ewe = (wd && d_we) ? d_wstrb : '0;
      chk1("if_ready", if_ready, wi);
      chk1("d_ready", d_ready, wd);
      chk1("mem_en", mem_en, wd | wi);
      chk32("mem_we", 32'(mem_we), 32'(ewe));
      if (wd || wi) chk32("mem_addr", 32'(mem_addr), 32'(wd ? d_addr : if_addr));
      if (wd && d_we) chk32("mem_wdata", mem_wdata, d_wdata);
      if (wd) begin
        busy = 1; own_d = 1;
        if (d_we) begin
          ref_mem[d_addr] = merge(ref_read(d_addr), d_wdata, d_wstrb);
          ref_wr[d_addr] = 1;
          resp_data = '0;
          resp_cyc = cyc + 1;
        end else begin
          resp_data = ref_read(d_addr);
          resp_cyc = cyc + LAT + 1;
        end
        free_cyc = resp_cyc + 1;
        streak = if_req ? ((streak < SMAX) ? streak + 1 : SMAX) : 0;
      end else if (wi) begin
        busy = 1; own_d = 0;
        resp_data = ref_read(if_addr);
        resp_cyc = cyc + LAT + 1;
        free_cyc = resp_cyc + 1;
        streak = 0;
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic run_one(input bit is_d, input bit we, input logic [SB-1:0] strb,
                         input logic [A_W-1:0] a, input logic [D_W-1:0] wdat,
                         output int lat, output logic [D_W-1:0] rd, output bit other_rv);
    int t0;
    bit got;
    if (is_d) begin
      d_req = 1; d_we = we; d_wstrb = strb; d_addr = a; d_wdata = wdat;
    end else begin
      if_req = 1; if_addr = a;
    end
    got = 0; t0 = 0; lat = -1; rd = '0; other_rv = 0;
    for (int i = 0; i < 50 && !got; i++) begin
      step();
      got = is_d ? s_d_ready : s_if_ready;
      t0 = cyc - 1;
    end
    if (!got) timeout("accept");
    if_req = 0; d_req = 0; d_we = 0;
    got = 0;
    for (int i = 0; i < 50 && !got; i++) begin
      step();
      if (is_d ? s_if_rv : s_d_rv) other_rv = 1;
      got = is_d ? s_d_rv : s_if_rv;
      if (got) begin
        lat = cyc - 1 - t0;
        rd = is_d ? s_d_rdata : s_if_rdata;
      end
    end
    if (!got) timeout("rvalid");
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && busy; i++) step();
    step();
  endtask

  initial begin
    int lat, t_d, gap, ng;
    logic [D_W-1:0] rd, d_got, if_got;
    bit orv, seen, done, ifp, dp;
    bit grants [6];

    // Reset state before any clock edge.
    step();
    step();
    rst = 0;
    step();

    // Single fetch.
    run_one(0, 0, '0, 14'h010, '0, lat, rd, orv);
    chk32("fetch_latency", 32'(lat), 32'd3);
    chk32("fetch_data", rd, 32'h00500093);
    chk1("fetch_no_d_rvalid", orv, 1'b0);

    // Partial write then read-back.
    run_one(1, 1, 4'b0011, 14'h020, 32'hDEADBEEF, lat, rd, orv);
    chk32("write_ack_latency", 32'(lat), 32'd1);
    chk32("write_ack_rdata", rd, 32'h0);
    run_one(1, 0, '0, 14'h020, '0, lat, rd, orv);
    chk32("read_after_write", rd, 32'h0000BEEF);
    chk32("read_latency", 32'(lat), 32'd3);

    // Contention: data first, fetch at the next idle cycle.
    if_req = 1; if_addr = 14'h010;
    d_req = 1; d_we = 0; d_addr = 14'h020;
    step();
    chk1("contention_d_first", s_d_ready, 1'b1);
    chk1("contention_if_waits", s_if_ready, 1'b0);
    t_d = cyc - 1; d_req = 0; gap = -1; done = 0;
    d_got = '0; if_got = '0;
    for (int i = 0; i < 30 && !done; i++) begin
      step();
      if (s_d_rv) d_got = s_d_rdata;
      if (s_if_ready) begin gap = cyc - 1 - t_d; if_req = 0; end
      if (s_if_rv) begin if_got = s_if_rdata; done = 1; end
    end
    if (!done) timeout("contention");
    chk32("contention_if_gap", 32'(gap), 32'd4);
    chk32("contention_d_data", d_got, 32'h0000BEEF);
    chk32("contention_if_data", if_got, 32'h00500093);

    // Starvation guard, from a clean streak.
    drain();
    rst = 1; step(); rst = 0; step();
    if_req = 1; if_addr = 14'h030; d_req = 1; d_we = 0;
    ng = 0;
    for (int i = 0; i < 200 && ng < 6; i++) begin
      d_addr = 14'($urandom_range(0, 63));
      step();
      if (s_d_ready) begin grants[ng] = 1; ng++; end
      else if (s_if_ready) begin grants[ng] = 0; ng++; if_req = 0; end
    end
    if (ng < 6) timeout("starve");
    d_req = 0; if_req = 0;
    for (int g = 0; g < 6; g++)
      chk1($sformatf("starve_grant%0d_is_data", g), grants[g], g != 4);

    // Reset one cycle after a read is accepted.
    drain();
    if_req = 1; if_addr = 14'h010; done = 0;
    for (int i = 0; i < 20 && !done; i++) begin step(); done = s_if_ready; end
    if (!done) timeout("reset_accept");
    if_req = 0;
    rst = 1;
    step();
    rst = 0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin step(); seen |= s_if_rv | s_d_rv; end
    chk1("reset_no_rvalid", seen, 1'b0);
    run_one(0, 0, '0, 14'h010, '0, lat, rd, orv);
    chk32("after_reset_fetch", rd, 32'h00500093);

    // Abandoned data request while a fetch is in WAIT.
    if_req = 1; if_addr = 14'h011; done = 0;
    for (int i = 0; i < 20 && !done; i++) begin step(); done = s_if_ready; end
    if (!done) timeout("abandon_accept");
    if_req = 0;
    d_req = 1; d_we = 1; d_wstrb = 4'hF; d_addr = 14'h005; d_wdata = 32'h12345678;
    step();
    chk1("abandon_no_d_ready", s_d_ready, 1'b0);
    chk1("abandon_no_mem_en", s_mem_en, 1'b0);
    d_req = 0; d_we = 0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin step(); seen |= s_d_rv; end
    chk1("abandon_no_d_rvalid", seen, 1'b0);
    chk32("abandon_mem_untouched", ref_read(14'h005), init_word(14'h005));

    // Random traffic with holds, abandons and mixed reads/writes.
    ifp = 0; dp = 0;
    for (int n = 0; n < 2000; n++) begin
      if (!ifp && $urandom_range(0, 2) == 0) begin
        ifp = 1; if_addr = 14'($urandom_range(0, 63));
      end else if (ifp && $urandom_range(0, 24) == 0) ifp = 0;
      if (!dp && $urandom_range(0, 1) == 0) begin
        dp = 1; d_we = 1'($urandom_range(0, 1)); d_wstrb = 4'($urandom);
        d_addr = 14'($urandom_range(0, 63)); d_wdata = $urandom;
      end else if (dp && $urandom_range(0, 24) == 0) dp = 0;
      if_req = ifp; d_req = dp;
      step();
      if (s_if_ready) ifp = 0;
      if (s_d_ready) dp = 0;
    end
    if_req = 0; d_req = 0;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_mem_arbiter
`default_nettype wire
